// File: rtl/keypad_lock_ctrl.sv
// Keypad code lock: collects a BCD entry from one-hot keypad codes, checks it
// against PASSWORD, counts failures, runs a BCD-seconds lockout and drives a buzzer.
module keypad_lock_ctrl #(
    parameter int                  DIGITS    = 3,
    parameter logic [4*DIGITS-1:0] PASSWORD  = 12'h246,
    parameter int                  MAX_TRIES = 3,
    parameter int                  LOCK_SECS = 20,
    parameter int                  CLK_HZ    = 50_000_000,
    parameter int                  KEY_HALF  = 50000,
    parameter int                  OK_HALF   = 25000,
    parameter int                  ERR_HALF  = 100000,
    parameter int                  KEY_LEN   = 10_000_000,
    parameter int                  OK_LEN    = 30_000_000,
    parameter int                  ERR_LEN   = 15_000_000
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic [15:0]           onehot,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  unlocked,
    output logic                  locked_out,
    output logic [3:0]            tries,
    output logic [7:0]            lock_remain,
    output logic                  buzzer
);
    localparam int              W          = 4 * DIGITS;
    localparam logic [W-1:0]    BLANK      = {DIGITS{4'hF}};
    localparam logic [W-1:0]    OPEN_GLYPH = {DIGITS{4'hA}};
    localparam logic [7:0]      LOCK_BCD   = {4'(LOCK_SECS / 10), 4'(LOCK_SECS % 10)};

    typedef enum logic [1:0] {S_ENTRY, S_OPEN, S_LOCK} state_t;
    typedef enum logic [2:0] {K_NONE, K_DIGIT, K_ENTER, K_CLEAR, K_ADMIN} key_t;
    typedef enum logic [1:0] {P_NONE, P_KEY, P_OK, P_ERR} pat_t;

    state_t      state, state_n;
    key_t        key_kind;
    pat_t        start, pat;
    logic [3:0]  key_digit;
    logic [15:0] prev_key;
    logic [W-1:0] disp_n;
    logic [3:0]  count, count_n, tries_n;
    logic [7:0]  remain_n;
    logic [31:0] sec_cnt, sec_n;
    logic [31:0] half_cnt, len_cnt, half_lim, len_lim;
    logic        tone, gap;

    function automatic logic [W-1:0] lock_glyph(input logic [7:0] secs);
        logic [31:0] ext;
        ext = {24'd0, secs};
        return ext[W-1:0];
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // A key event is a defined code that differs from last cycle's sample.
    always_comb begin
        key_kind  = K_NONE;
        key_digit = 4'd0;
        case (onehot)
            16'h0008: begin key_kind = K_DIGIT; key_digit = 4'd0; end
            16'h0080: begin key_kind = K_DIGIT; key_digit = 4'd1; end
            16'h0040: begin key_kind = K_DIGIT; key_digit = 4'd2; end
            16'h0020: begin key_kind = K_DIGIT; key_digit = 4'd3; end
            16'h0800: begin key_kind = K_DIGIT; key_digit = 4'd4; end
            16'h0400: begin key_kind = K_DIGIT; key_digit = 4'd5; end
            16'h0200: begin key_kind = K_DIGIT; key_digit = 4'd6; end
            16'h8000: begin key_kind = K_DIGIT; key_digit = 4'd7; end
            16'h4000: begin key_kind = K_DIGIT; key_digit = 4'd8; end
            16'h2000: begin key_kind = K_DIGIT; key_digit = 4'd9; end
            16'h0001: key_kind = K_ENTER;
            16'h1000: key_kind = K_CLEAR;
            16'h0100: key_kind = K_ADMIN;
            default:  key_kind = K_NONE;
        endcase
        if (onehot == prev_key) key_kind = K_NONE;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state       <= S_ENTRY;
            prev_key    <= 16'h0000;
            disp        <= BLANK;
            count       <= 4'd0;
            tries       <= 4'd0;
            lock_remain <= 8'h00;
            sec_cnt     <= 32'd0;
        end else begin
            state       <= state_n;
            prev_key    <= onehot;
            disp        <= disp_n;
            count       <= count_n;
            tries       <= tries_n;
            lock_remain <= remain_n;
            sec_cnt     <= sec_n;
        end
    end

    always_comb begin
        state_n  = state;
        disp_n   = disp;
        count_n  = count;
        tries_n  = tries;
        remain_n = lock_remain;
        sec_n    = sec_cnt;
        start    = P_NONE;
        case (state)
            S_ENTRY: begin
                case (key_kind)
                    K_DIGIT: begin
                        if (count < 4'(DIGITS)) begin
                            disp_n  = (disp << 4) | W'(key_digit);
                            count_n = count + 4'd1;
                            start   = P_KEY;
                        end
                    end
                    K_CLEAR: begin
                        disp_n  = BLANK;
                        count_n = 4'd0;
                        start   = P_KEY;
                    end
                    K_ENTER: begin
                        count_n = 4'd0;
                        if (count == 4'(DIGITS) && disp == PASSWORD) begin
                            state_n = S_OPEN;
                            tries_n = 4'd0;
                            disp_n  = OPEN_GLYPH;
                            start   = P_OK;
                        end else begin
                            disp_n = BLANK;
                            start  = P_ERR;
                            if (tries + 4'd1 == 4'(MAX_TRIES)) begin
                                state_n  = S_LOCK;
                                tries_n  = 4'd0;
                                remain_n = LOCK_BCD;
                                sec_n    = 32'd0;
                                disp_n   = lock_glyph(LOCK_BCD);
                            end else begin
                                tries_n = tries + 4'd1;
                            end
                        end
                    end
                    K_ADMIN: begin
                        tries_n = 4'd0;
                        disp_n  = BLANK;
                        count_n = 4'd0;
                    end
                    default: ;
                endcase
            end
            S_OPEN: begin
                disp_n = OPEN_GLYPH;
                if (key_kind == K_ENTER || key_kind == K_CLEAR) begin
                    state_n = S_ENTRY;
                    disp_n  = BLANK;
                    count_n = 4'd0;
                    start   = P_KEY;
                end
            end
            S_LOCK: begin
                if (key_kind == K_ADMIN) begin
                    state_n  = S_ENTRY;
                    tries_n  = 4'd0;
                    disp_n   = BLANK;
                    count_n  = 4'd0;
                    remain_n = 8'h00;
                    sec_n    = 32'd0;
                end else if (sec_cnt == 32'(CLK_HZ - 1)) begin
                    sec_n    = 32'd0;
                    remain_n = bcd_dec(lock_remain);
                    if (remain_n == 8'h00) begin
                        state_n = S_ENTRY;
                        disp_n  = BLANK;
                    end else begin
                        disp_n = lock_glyph(remain_n);
                    end
                end else begin
                    sec_n = sec_cnt + 32'd1;
                end
            end
            default: state_n = S_ENTRY;
        endcase
    end

    assign unlocked   = (state == S_OPEN);
    assign locked_out = (state == S_LOCK);

    always_comb begin
        half_lim = 32'(KEY_HALF - 1);
        len_lim  = 32'(KEY_LEN - 1);
        case (pat)
            P_OK:    begin half_lim = 32'(OK_HALF - 1);  len_lim = 32'(OK_LEN - 1);  end
            P_ERR:   begin half_lim = 32'(ERR_HALF - 1); len_lim = 32'(ERR_LEN - 1); end
            default: ;
        endcase
    end

    // A new pattern always restarts both counters, overriding any running one.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            pat      <= P_NONE;
            tone     <= 1'b0;
            half_cnt <= 32'd0;
            len_cnt  <= 32'd0;
        end else if (start != P_NONE) begin
            pat      <= start;
            tone     <= 1'b1;
            half_cnt <= 32'd0;
            len_cnt  <= 32'd0;
        end else if (pat != P_NONE) begin
            if (len_cnt == len_lim) begin
                pat  <= P_NONE;
                tone <= 1'b0;
            end else begin
                len_cnt <= len_cnt + 32'd1;
                if (half_cnt == half_lim) begin
                    half_cnt <= 32'd0;
                    tone     <= ~tone;
                end else begin
                    half_cnt <= half_cnt + 32'd1;
                end
            end
        end
    end

    assign gap    = (pat == P_ERR) && (len_cnt >= 32'(ERR_LEN / 3)) && (len_cnt <= 32'(2 * ERR_LEN / 3));
    assign buzzer = tone & ~gap;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed steps plus random key presses, every
// cycle compared against a behavioural model of the lock.
module tb_keypad_lock_ctrl;
    localparam int          DIGITS    = 3;
    localparam logic [11:0] PASSWORD  = 12'h246;
    localparam int          MAX_TRIES = 3;
    localparam int          LOCK_SECS = 20;
    localparam int          CLK_HZ    = 100;
    localparam int          HALF      = 2;
    localparam int          LEN       = 40;

    localparam logic [15:0] K_ENTER = 16'h0001;
    localparam logic [15:0] K_CLEAR = 16'h1000;
    localparam logic [15:0] K_ADMIN = 16'h0100;
    localparam logic [15:0] DCODE [10] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800,
                                           16'h0400, 16'h0200, 16'h8000, 16'h4000, 16'h2000};
    localparam logic [15:0] RTAB [20] = '{16'h0040, 16'h0040, 16'h0040, 16'h0800, 16'h0800,
                                          16'h0800, 16'h0200, 16'h0200, 16'h0200, 16'h0008,
                                          16'h0080, 16'h8000, 16'h2000, 16'h0001, 16'h0001,
                                          16'h0001, 16'h1000, 16'h0100, 16'h0041, 16'h0003};

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic [15:0] onehot = 16'h0000;
    logic [11:0] disp;
    logic        unlocked, locked_out, buzzer;
    logic [3:0]  tries;
    logic [7:0]  lock_remain;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lock_cyc = 0;

    // Model: mode 0=entry 1=open 2=lock; pattern 0=none 1=key 2=ok 3=err
    int          m_mode, m_tries, m_secs, m_tick, m_pat, m_age;
    int          m_digits[$];
    logic [15:0] m_prev;

    always #5 clk = ~clk;

    keypad_lock_ctrl #(
        .DIGITS(DIGITS), .PASSWORD(PASSWORD), .MAX_TRIES(MAX_TRIES), .LOCK_SECS(LOCK_SECS),
        .CLK_HZ(CLK_HZ), .KEY_HALF(HALF), .OK_HALF(HALF), .ERR_HALF(HALF),
        .KEY_LEN(LEN), .OK_LEN(LEN), .ERR_LEN(LEN)
    ) dut (
        .clk(clk), .RSTn(RSTn), .onehot(onehot), .disp(disp), .unlocked(unlocked),
        .locked_out(locked_out), .tries(tries), .lock_remain(lock_remain), .buzzer(buzzer)
    );

    function automatic int key_val(input logic [15:0] c);
        for (int i = 0; i < 10; i++) if (c == DCODE[i]) return i;
        if (c == K_ENTER) return 10;
        if (c == K_CLEAR) return 11;
        if (c == K_ADMIN) return 12;
        return -1;
    endfunction

    function automatic int bcd(input int s);
        return (s / 10) * 16 + (s % 10);
    endfunction

    function automatic logic [11:0] entry_value();
        logic [11:0] d;
        d = 12'hFFF;
        foreach (m_digits[i]) d = (d << 4) | 12'(m_digits[i]);
        return d;
    endfunction

    function automatic logic [11:0] exp_disp();
        if (m_mode == 1) return 12'hAAA;
        if (m_mode == 2) return 12'(bcd(m_secs));
        return entry_value();
    endfunction

    function automatic logic exp_buzz();
        if (m_pat == 0) return 1'b0;
        if (m_pat == 3 && m_age >= LEN / 3 && m_age <= 2 * LEN / 3) return 1'b0;
        return ((m_age / HALF) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_tries = 0; m_secs = 0; m_tick = 0; m_pat = 0; m_age = 0;
        m_prev = 16'h0000;
        m_digits.delete();
    endtask

    task automatic model_tick(input logic [15:0] code);
        int k;
        int st;
        k = (code != m_prev) ? key_val(code) : -1;
        m_prev = code;
        st = 0;
        if (m_mode == 0) begin
            if (k >= 0 && k <= 9) begin
                if (m_digits.size() < DIGITS) begin m_digits.push_back(k); st = 1; end
            end else if (k == 11) begin
                m_digits.delete(); st = 1;
            end else if (k == 10) begin
                if (m_digits.size() == DIGITS && entry_value() == PASSWORD) begin
                    m_mode = 1; m_tries = 0; st = 2;
                end else begin
                    m_tries++; st = 3;
                    if (m_tries == MAX_TRIES) begin
                        m_mode = 2; m_tries = 0; m_secs = LOCK_SECS; m_tick = 0;
                    end
                end
                m_digits.delete();
            end else if (k == 12) begin
                m_tries = 0; m_digits.delete();
            end
        end else if (m_mode == 1) begin
            if (k == 10 || k == 11) begin m_mode = 0; m_digits.delete(); st = 1; end
        end else begin
            if (k == 12) begin
                m_mode = 0; m_tries = 0; m_secs = 0;
            end else begin
                m_tick++;
                if (m_tick == CLK_HZ) begin
                    m_tick = 0; m_secs--;
                    if (m_secs == 0) m_mode = 0;
                end
            end
        end
        if (st != 0) begin
            m_pat = st; m_age = 0;
        end else if (m_pat != 0) begin
            m_age++;
            if (m_age == LEN) m_pat = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("disp", 32'(disp), 32'(exp_disp()));
        chk("unlocked", 32'(unlocked), 32'(m_mode == 1));
        chk("locked_out", 32'(locked_out), 32'(m_mode == 2));
        chk("tries", 32'(tries), 32'(m_tries));
        chk("lock_remain", 32'(lock_remain), 32'((m_mode == 2) ? bcd(m_secs) : 0));
        chk("buzzer", 32'(buzzer), 32'(exp_buzz()));
    endtask

    task automatic step(input logic [15:0] code);
        onehot = code;
        @(posedge clk);
        cyc++;
        if (!RSTn) model_reset();
        else model_tick(code);
        #1;
        check_all();
    endtask

    task automatic press(input logic [15:0] code, input int hold);
        repeat (hold) step(code);
        step(16'h0000);
    endtask

    task automatic enter3(input int a, input int b, input int c);
        press(DCODE[a], 3);
        press(DCODE[b], 3);
        press(DCODE[c], 3);
        press(K_ENTER, 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) step(16'h0000);
        chk("rst_disp", 32'(disp), 32'h0FFF);
        chk("rst_buzzer", 32'(buzzer), 32'h0);
        @(negedge clk);
        RSTn = 1'b1;
        step(16'h0000);

        // Correct code opens; OK pattern then silence
        enter3(2, 4, 6);
        chk("open_disp", 32'(disp), 32'h0AAA);
        chk("open_unlocked", 32'(unlocked), 32'h1);
        chk("open_tries", 32'(tries), 32'h0);
        repeat (45) step(16'h0000);
        chk("ok_silent", 32'(buzzer), 32'h0);
        press(K_CLEAR, 3);
        chk("close_disp", 32'(disp), 32'h0FFF);

        // Fourth digit ignored once full
        press(DCODE[2], 3);
        press(DCODE[4], 3);
        press(DCODE[6], 3);
        press(DCODE[7], 3);
        chk("full_disp", 32'(disp), 32'h0246);
        press(K_ENTER, 3);
        chk("full_open", 32'(unlocked), 32'h1);
        press(K_ENTER, 3);

        // Short entry is a failure; ADMIN clears tries
        press(DCODE[2], 3);
        press(K_ENTER, 3);
        chk("short_tries", 32'(tries), 32'h1);
        press(K_ADMIN, 3);
        chk("admin_tries", 32'(tries), 32'h0);

        // Three failures into lockout, then timed countdown
        enter3(1, 2, 3);
        chk("fail1_tries", 32'(tries), 32'h1);
        enter3(1, 2, 3);
        chk("fail2_tries", 32'(tries), 32'h2);
        enter3(1, 2, 3);
        lock_cyc = cyc - 3;
        chk("lock_flag", 32'(locked_out), 32'h1);
        chk("lock_tries", 32'(tries), 32'h0);
        chk("lock_remain20", 32'(lock_remain), 32'h20);
        while (cyc < lock_cyc + 99) step(16'h0000);
        chk("lock_pre_tick", 32'(lock_remain), 32'h20);
        step(16'h0000);
        chk("lock_remain19", 32'(lock_remain), 32'h19);
        press(DCODE[2], 3);
        press(K_ENTER, 3);
        chk("lock_ignore", 32'(locked_out), 32'h1);
        while (cyc < lock_cyc + 1999) step(16'h0000);
        chk("lock_last", 32'(lock_remain), 32'h01);
        step(16'h0000);
        chk("lock_done", 32'(locked_out), 32'h0);
        chk("lock_done_disp", 32'(disp), 32'h0FFF);

        // ADMIN aborts a lockout on the sampling edge
        enter3(1, 2, 3);
        enter3(1, 2, 3);
        enter3(1, 2, 3);
        chk("relock", 32'(locked_out), 32'h1);
        step(K_ADMIN);
        chk("abort_flag", 32'(locked_out), 32'h0);
        chk("abort_tries", 32'(tries), 32'h0);
        step(16'h0000);

        // Held key gives one event; multi-hot ignored
        press(DCODE[2], 10);
        chk("hold_disp", 32'(disp), 32'h0FF2);
        press(16'h0041, 3);
        chk("multihot_disp", 32'(disp), 32'h0FF2);

        // Random presses, including direct key-to-key changes
        for (int n = 0; n < 250; n++) begin
            logic [15:0] c;
            c = RTAB[$urandom_range(0, 19)];
            repeat ($urandom_range(1, 4)) step(c);
            if ($urandom_range(0, 3) != 0) step(16'h0000);
        end

        // Asynchronous reset in the middle of a lockout
        press(K_CLEAR, 2);
        press(K_ADMIN, 2);
        press(K_CLEAR, 2);
        enter3(1, 2, 3);
        enter3(1, 2, 3);
        enter3(1, 2, 3);
        chk("pre_rst_lock", 32'(locked_out), 32'h1);
        repeat (7) step(16'h0000);
        #2;
        RSTn = 1'b0;
        #1;
        chk("arst_disp", 32'(disp), 32'h0FFF);
        chk("arst_locked", 32'(locked_out), 32'h0);
        chk("arst_unlocked", 32'(unlocked), 32'h0);
        chk("arst_tries", 32'(tries), 32'h0);
        chk("arst_remain", 32'(lock_remain), 32'h00);
        chk("arst_buzzer", 32'(buzzer), 32'h0);
        model_reset();
        repeat (2) step(16'h0000);
        RSTn = 1'b1;
        enter3(2, 4, 6);
        chk("post_rst_open", 32'(unlocked), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
